// File: rtl/gray_pkg.sv
// Shared binary/Gray conversions for the counter, converters and FIFO pointer logic.
// Operands are zero-extended to MAX_W, so results are valid for any width up to MAX_W.
package gray_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] gvec_t;

  function automatic gvec_t b2g(input gvec_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // bin[i] is the XOR of gray[MAX_W-1:i]; zero upper bits leave narrow values intact
  function automatic gvec_t g2b(input gvec_t gray);
    gvec_t bin;
    bin[MAX_W-1] = gray[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Up/down Gray counter with parallel load and wrap or saturate at terminal count.
// Latency: gray_q/bin_q/wrapped one clk after inputs are sampled; tc is combinational from bin_q/up.
// Backpressure: none; en is the only stall, load overrides en.
module gray_counter
  import gray_pkg::*;
#(
  parameter int                 WIDTH     = 4,
  parameter bit                 WRAP      = 1'b1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             tc,
  output logic             wrapped
);

  localparam gvec_t            RESET_GRAY_EXT = b2g(gvec_t'(RESET_VAL));
  localparam logic [WIDTH-1:0] RESET_GRAY     = RESET_GRAY_EXT[WIDTH-1:0];

  gvec_t            load_ext;
  gvec_t            gray_ext;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrapped_nxt;
  logic             unused_hi;

  assign tc = (bin_q == {WIDTH{up}});

  always_comb begin
    load_ext = g2b(gvec_t'(load_val));
    load_bin = load_is_gray ? load_ext[WIDTH-1:0] : load_val;
  end

  always_comb begin
    bin_nxt     = bin_q;
    wrapped_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      if (tc) begin
        // At terminal count the wrapped value is the bitwise complement in both directions
        if (WRAP) begin
          bin_nxt     = ~bin_q;
          wrapped_nxt = 1'b1;
        end
      end else begin
        bin_nxt = up ? bin_q + 1'b1 : bin_q - 1'b1;
      end
    end
  end

  // Gray is encoded from the next binary value and registered, so gray_q is glitch-free
  always_comb begin
    gray_ext = b2g(gvec_t'(bin_nxt));
    gray_nxt = gray_ext[WIDTH-1:0];
  end

  assign unused_hi = ^{load_ext[MAX_W-1:WIDTH], gray_ext[MAX_W-1:WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= RESET_VAL;
      gray_q  <= RESET_GRAY;
      wrapped <= 1'b0;
    end else begin
      bin_q   <= bin_nxt;
      gray_q  <= gray_nxt;
      wrapped <= wrapped_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomised checks of gray_counter in wrap (ua) and saturate (ub) configurations.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic       load_is_gray = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] gray_a, bin_a, gray_b, bin_b;
  logic       tc_a, tc_b, wrapped_a, wrapped_b;

  int checks = 0;
  int errors = 0;

  logic [3:0] gtab [0:15] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'd0)) ua (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .gray_q(gray_a), .bin_q(bin_a), .tc(tc_a), .wrapped(wrapped_a)
  );

  gray_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'd0)) ub (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .gray_q(gray_b), .bin_q(bin_b), .tc(tc_b), .wrapped(wrapped_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] tb_b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] tb_g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    step();
    step();
    checks++; if (bin_a !== 4'd0) begin errors++; $display("FAIL reset_bin got %h want 0", bin_a); end
    checks++; if (gray_a !== 4'd0) begin errors++; $display("FAIL reset_gray got %h want 0", gray_a); end
    checks++; if (wrapped_a !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %b want 0", wrapped_a); end
    checks++; if (tc_a !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", tc_a); end
    checks++; if (bin_b !== 4'd0) begin errors++; $display("FAIL reset_bin_b got %h want 0", bin_b); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] prev_gray;
    logic [3:0] exp;
    prev_gray = 4'h0;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (tc_a !== (i == 16)) begin
        errors++; $display("FAIL up_tc step %0d got %b want %b", i, tc_a, (i == 16));
      end
      step();
      exp = 4'(i % 16);
      checks++; if (bin_a !== exp) begin errors++; $display("FAIL up_bin step %0d got %h want %h", i, bin_a, exp); end
      checks++; if (gray_a !== gtab[exp]) begin errors++; $display("FAIL up_gray step %0d got %h want %h", i, gray_a, gtab[exp]); end
      checks++;
      if ($countones(gray_a ^ prev_gray) != 1) begin
        errors++; $display("FAIL up_onebit step %0d got %h from %h want one bit change", i, gray_a, prev_gray);
      end
      checks++;
      if (wrapped_a !== (i == 16)) begin
        errors++; $display("FAIL up_wrapped step %0d got %b want %b", i, wrapped_a, (i == 16));
      end
      prev_gray = gray_a;
    end
    en = 1'b0;
    step();
    checks++; if (wrapped_a !== 1'b0) begin errors++; $display("FAIL hold_wrapped got %b want 0", wrapped_a); end
    checks++; if (bin_a !== 4'd0) begin errors++; $display("FAIL hold_bin got %h want 0", bin_a); end
    checks++; if (bin_b !== 4'd15) begin errors++; $display("FAIL sat_up_bin_b got %h want f", bin_b); end
    checks++; if (wrapped_b !== 1'b0) begin errors++; $display("FAIL sat_up_wrapped_b got %b want 0", wrapped_b); end
  endtask

  task automatic test_load_gray();
    load = 1'b1; load_is_gray = 1'b1; load_val = 4'b1100;
    step();
    checks++; if (bin_a !== 4'd8) begin errors++; $display("FAIL gload_bin got %h want 8", bin_a); end
    checks++; if (gray_a !== 4'hC) begin errors++; $display("FAIL gload_gray got %h want c", gray_a); end
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    checks++; if (bin_a !== 4'd7) begin errors++; $display("FAIL gload_dn_bin got %h want 7", bin_a); end
    checks++; if (gray_a !== 4'h4) begin errors++; $display("FAIL gload_dn_gray got %h want 4", gray_a); end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; load_is_gray = 1'b0; load_val = 4'd0; en = 1'b0;
    step();
    checks++; if (bin_b !== 4'd0) begin errors++; $display("FAIL sat_load_bin got %h want 0", bin_b); end
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bin_b !== 4'd0) begin errors++; $display("FAIL sat_bin cyc %0d got %h want 0", k, bin_b); end
      checks++; if (tc_b !== 1'b1) begin errors++; $display("FAIL sat_tc cyc %0d got %b want 1", k, tc_b); end
      checks++; if (wrapped_b !== 1'b0) begin errors++; $display("FAIL sat_wrapped cyc %0d got %b want 0", k, wrapped_b); end
      if (k == 0) begin
        checks++; if (bin_a !== 4'hF) begin errors++; $display("FAIL dnwrap_bin got %h want f", bin_a); end
        checks++; if (wrapped_a !== 1'b1) begin errors++; $display("FAIL dnwrap_wrapped got %b want 1", wrapped_a); end
      end
    end
    up = 1'b1;
    step();
    checks++; if (bin_b !== 4'd1) begin errors++; $display("FAIL sat_leave_bin got %h want 1", bin_b); end
    checks++; if (gray_b !== 4'h1) begin errors++; $display("FAIL sat_leave_gray got %h want 1", gray_b); end
    checks++; if (tc_b !== 1'b0) begin errors++; $display("FAIL sat_leave_tc got %b want 0", tc_b); end
    en = 1'b0;
  endtask

  task automatic test_reset_priority();
    load = 1'b1; load_is_gray = 1'b0; load_val = 4'd5;
    step();
    checks++; if (bin_a !== 4'd5) begin errors++; $display("FAIL rp_pre_bin got %h want 5", bin_a); end
    rst = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1; up = 1'b1;
    step();
    checks++; if (bin_a !== 4'd0) begin errors++; $display("FAIL rp_bin got %h want 0", bin_a); end
    checks++; if (gray_a !== 4'd0) begin errors++; $display("FAIL rp_gray got %h want 0", gray_a); end
    checks++; if (wrapped_a !== 1'b0) begin errors++; $display("FAIL rp_wrapped got %b want 0", wrapped_a); end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_load_over_en();
    load = 1'b1; en = 1'b1; up = 1'b1; load_is_gray = 1'b0; load_val = 4'b0011;
    step();
    checks++; if (bin_a !== 4'd3) begin errors++; $display("FAIL lov_bin got %h want 3", bin_a); end
    checks++; if (gray_a !== 4'h2) begin errors++; $display("FAIL lov_gray got %h want 2", gray_a); end
    checks++; if (bin_b !== 4'd3) begin errors++; $display("FAIL lov_bin_b got %h want 3", bin_b); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] ea, eb;
    logic       ew;
    ea = 4'd3; eb = 4'd3;
    for (int n = 0; n < 200; n++) begin
      en           = 1'($urandom_range(0, 1));
      up           = 1'($urandom_range(0, 1));
      load         = ($urandom_range(0, 7) == 0);
      load_is_gray = 1'($urandom_range(0, 1));
      load_val     = 4'($urandom_range(0, 15));
      ew = 1'b0;
      if (load) begin
        ea = load_is_gray ? tb_g2b(load_val) : load_val;
        eb = ea;
      end else if (en) begin
        ew = (up && ea == 4'hF) || (!up && ea == 4'h0);
        ea = up ? ea + 4'd1 : ea - 4'd1;
        if (!((up && eb == 4'hF) || (!up && eb == 4'h0))) eb = up ? eb + 4'd1 : eb - 4'd1;
      end
      step();
      checks++;
      if (bin_a !== ea || gray_a !== tb_b2g(ea) || wrapped_a !== ew) begin
        errors++;
        $display("FAIL rnd_a cyc %0d got bin %h gray %h wr %b want bin %h gray %h wr %b",
                 n, bin_a, gray_a, wrapped_a, ea, tb_b2g(ea), ew);
      end
      checks++;
      if (bin_b !== eb || gray_b !== tb_b2g(eb) || wrapped_b !== 1'b0) begin
        errors++;
        $display("FAIL rnd_b cyc %0d got bin %h gray %h wr %b want bin %h gray %h wr 0",
                 n, bin_b, gray_b, wrapped_b, eb, tb_b2g(eb));
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_gray();
    test_saturate();
    test_reset_priority();
    test_load_over_en();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
